// File: rtl/cdb_result_arbiter.sv
// cdb_result_arbiter
//   Shares the common data bus between the ALU, MUL and DIV result producers.
//   Each producer feeds a small holding FIFO (the units cannot stall); a
//   round-robin arbiter picks one head entry per cycle and loads it into a
//   registered CDB broadcast. A flush discards every buffered result.
//
//   Optional feature macro: CDB_BYPASS_EN
//     When defined, a valid result arriving at an empty FIFO may win
//     arbitration in the same cycle and load straight into the output
//     register (1-edge latency). When undefined, every result goes through
//     its FIFO (2-edge latency).
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   flush                discard all pending results
//   {alu,mul,div}_valid  result present this cycle
//   {alu,mul,div}_value  32-bit result
//   {alu,mul,div}_pc     PC of producing instruction
//   {alu,mul,div}_tag    destination physical tag
//   {alu,mul,div}_full   FIFO holds DEPTH entries
//   cdb_valid/value/pc/tag/src  registered broadcast (src: 0=ALU 1=MUL 2=DIV)
//   cdb_overflow         sticky: a push arrived while its FIFO was full
module cdb_result_arbiter #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alu_valid,
    input  logic [31:0]      alu_value,
    input  logic [31:0]      alu_pc,
    input  logic [TAG_W-1:0] alu_tag,
    output logic             alu_full,
    input  logic             mul_valid,
    input  logic [31:0]      mul_value,
    input  logic [31:0]      mul_pc,
    input  logic [TAG_W-1:0] mul_tag,
    output logic             mul_full,
    input  logic             div_valid,
    input  logic [31:0]      div_value,
    input  logic [31:0]      div_pc,
    input  logic [TAG_W-1:0] div_tag,
    output logic             div_full,
    output logic             cdb_valid,
    output logic [31:0]      cdb_value,
    output logic [31:0]      cdb_pc,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [1:0]       cdb_src,
    output logic             cdb_overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Sources gathered into arrays indexed by source id (0=ALU 1=MUL 2=DIV).
    logic [2:0]       in_valid;
    logic [31:0]      in_value [3];
    logic [31:0]      in_pc    [3];
    logic [TAG_W-1:0] in_tag   [3];

    assign in_valid    = {div_valid, mul_valid, alu_valid};
    assign in_value[0] = alu_value;
    assign in_value[1] = mul_value;
    assign in_value[2] = div_value;
    assign in_pc[0]    = alu_pc;
    assign in_pc[1]    = mul_pc;
    assign in_pc[2]    = div_pc;
    assign in_tag[0]   = alu_tag;
    assign in_tag[1]   = mul_tag;
    assign in_tag[2]   = div_tag;

    logic [31:0]      mem_value [3][DEPTH];
    logic [31:0]      mem_pc    [3][DEPTH];
    logic [TAG_W-1:0] mem_tag   [3][DEPTH];
    logic [PW-1:0]    wr_ptr    [3];
    logic [PW-1:0]    rd_ptr    [3];
    logic [CW-1:0]    count     [3];

    logic [2:0] nonempty, full_vec, bypass_ok, req, push, pop;
    logic [1:0] rr_last, win, cand0, cand1, cand2;
    logic       grant;
    logic       overflow_set;
    logic [31:0]      sel_value, sel_pc;
    logic [TAG_W-1:0] sel_tag;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    assign alu_full = full_vec[0];
    assign mul_full = full_vec[1];
    assign div_full = full_vec[2];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nonempty[i] = (count[i] != '0);
            full_vec[i] = (count[i] == FULL_CNT);
`ifdef CDB_BYPASS_EN
            bypass_ok[i] = in_valid[i] && !nonempty[i] && !flush;
`else
            bypass_ok[i] = 1'b0;
`endif
            req[i] = nonempty[i] || bypass_ok[i];
        end
    end

    // Round-robin: search starts one past the last winner and wraps.
    always_comb begin
        cand0 = next_src(rr_last);
        cand1 = next_src(cand0);
        cand2 = next_src(cand1);
        win   = cand0;
        if (req[cand0])      win = cand0;
        else if (req[cand1]) win = cand1;
        else if (req[cand2]) win = cand2;
        grant = (|req) && !flush;
    end

    // A bypassing winner is not written to its FIFO; a pop never frees
    // space for a push in the same cycle since the full test uses the
    // pre-edge count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pop[i]  = grant && (win == 2'(i)) && nonempty[i];
            push[i] = in_valid[i] && !flush && !full_vec[i]
                      && !(grant && (win == 2'(i)) && bypass_ok[i]);
        end
        overflow_set = |(in_valid & full_vec) && !flush;
    end

    always_comb begin
        sel_value = mem_value[win][rd_ptr[win]];
        sel_pc    = mem_pc[win][rd_ptr[win]];
        sel_tag   = mem_tag[win][rd_ptr[win]];
`ifdef CDB_BYPASS_EN
        if (bypass_ok[win]) begin
            sel_value = in_value[win];
            sel_pc    = in_pc[win];
            sel_tag   = in_tag[win];
        end
`endif
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_value[i][wr_ptr[i]] <= in_value[i];
                mem_pc[i][wr_ptr[i]]    <= in_pc[i];
                mem_tag[i][wr_ptr[i]]   <= in_tag[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_last      <= 2'd2;
            cdb_valid    <= 1'b0;
            cdb_value    <= '0;
            cdb_pc       <= '0;
            cdb_tag      <= '0;
            cdb_src      <= 2'd0;
            cdb_overflow <= 1'b0;
        end else begin
            if (overflow_set)
                cdb_overflow <= 1'b1;
            if (flush) begin
                for (int i = 0; i < 3; i++) begin
                    count[i]  <= '0;
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end
                rr_last   <= 2'd2;
                cdb_valid <= 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                end
                cdb_valid <= grant;
                if (grant) begin
                    rr_last   <= win;
                    cdb_value <= sel_value;
                    cdb_pc    <= sel_pc;
                    cdb_tag   <= sel_tag;
                    cdb_src   <= win;
                end
            end
        end
    end

endmodule
